// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter driven by an oversampling strobe.
// Frames are start bit, 5..9 data bits sent LSB first, optional even/odd
// parity, then 1, 1.5 or 2 stop bits. A break request holds the line low
// while asserted and is followed by one stop period without a done pulse.
// Ports:
//   clk, reset_in        clock, async active-low reset
//   s_tick               oversampling strobe, OS_TICKS per bit period
//   tx_valid/tx_ready    frame handshake; tx_data is the payload
//   cfg_dbits/parity/stop frame format, latched on acceptance
//   send_break           hold the line low (only honoured in IDLE)
//   tx                   registered serial line, idle high
//   tx_done_tick         one-cycle pulse on the final stop tick of a frame
//   busy                 state is not IDLE
module uart_tx_cfg #(
  parameter int unsigned OS_TICKS   = 16,
  parameter int unsigned MAX_DATA_W = 9
) (
  input  logic                  clk,
  input  logic                  reset_in,
  input  logic                  s_tick,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [MAX_DATA_W-1:0] tx_data,
  input  logic [3:0]            cfg_dbits,
  input  logic [1:0]            cfg_parity,
  input  logic [1:0]            cfg_stop,
  input  logic                  send_break,
  output logic                  tx,
  output logic                  tx_done_tick,
  output logic                  busy
);

  localparam int unsigned TICK_W = $clog2(2 * OS_TICKS);
  localparam int unsigned BIT_W  = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } state_t;

  state_t                  state;
  logic [TICK_W-1:0]       tick_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [MAX_DATA_W-1:0]   shreg;
  logic [BIT_W-1:0]        dbits_last_q;
  logic                    par_en_q;
  logic                    par_bit_q;
  logic [1:0]              stop_q;
  logic                    brk_seq_q;
  logic                    ready_en;
  logic                    tx_q;

  logic [BIT_W-1:0]        dbits_last_c;
  logic [MAX_DATA_W-1:0]   data_mask_c;
  logic                    par_c;
  logic [TICK_W-1:0]       stop_last_c;
  logic                    tick_last_c;

  // Index of the last data bit; out-of-range counts fall back to 8 bits.
  always_comb begin
    dbits_last_c = BIT_W'(7);
    if (cfg_dbits >= 4'd5 && cfg_dbits <= 4'd9) dbits_last_c = cfg_dbits - 4'd1;
  end

  // Parity covers only the bits that will actually be shifted out.
  always_comb begin
    data_mask_c = '0;
    for (int i = 0; i < MAX_DATA_W; i++) data_mask_c[i] = (BIT_W'(i) <= dbits_last_c);
    par_c = (^(tx_data & data_mask_c)) ^ (cfg_parity == 2'b10);
  end

  // Final stop tick index for the latched stop length.
  always_comb begin
    case (stop_q)
      2'b00:   stop_last_c = TICK_W'(OS_TICKS - 1);
      2'b01:   stop_last_c = TICK_W'(3 * OS_TICKS / 2 - 1);
      default: stop_last_c = TICK_W'(2 * OS_TICKS - 1);
    endcase
  end

  assign tick_last_c  = (tick_cnt == TICK_W'(OS_TICKS - 1));
  // ready_en keeps tx_ready low until the first clock after reset release.
  assign tx_ready     = (state == IDLE) && !send_break && ready_en;
  assign busy         = (state != IDLE);
  assign tx_done_tick = (state == STOP) && s_tick && (tick_cnt == stop_last_c) && !brk_seq_q;
  assign tx           = tx_q;

  // Transmit sequencer; every transition except accept and break is tick-gated.
  always_ff @(posedge clk or negedge reset_in) begin
    if (!reset_in) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      dbits_last_q <= '0;
      par_en_q     <= 1'b0;
      par_bit_q    <= 1'b0;
      stop_q       <= '0;
      brk_seq_q    <= 1'b0;
      ready_en     <= 1'b0;
      tx_q         <= 1'b1;
    end else begin
      ready_en <= 1'b1;
      case (state)
        IDLE: begin
          if (send_break) begin
            state <= BREAK;
            tx_q  <= 1'b0;
          end else if (tx_valid && ready_en) begin
            state        <= START;
            shreg        <= tx_data;
            dbits_last_q <= dbits_last_c;
            par_en_q     <= (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
            par_bit_q    <= par_c;
            stop_q       <= cfg_stop;
            brk_seq_q    <= 1'b0;
            tick_cnt     <= '0;
            bit_cnt      <= '0;
            tx_q         <= 1'b0;
          end
        end
        START: begin
          if (s_tick) begin
            if (tick_last_c) begin
              tick_cnt <= '0;
              state    <= DATA;
              tx_q     <= shreg[0];
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (tick_last_c) begin
              tick_cnt <= '0;
              if (bit_cnt == dbits_last_q) begin
                if (par_en_q) begin
                  state <= PARITY;
                  tx_q  <= par_bit_q;
                end else begin
                  state <= STOP;
                  tx_q  <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                shreg   <= {1'b0, shreg[MAX_DATA_W-1:1]};
                tx_q    <= shreg[1];
              end
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        PARITY: begin
          if (s_tick) begin
            if (tick_last_c) begin
              tick_cnt <= '0;
              state    <= STOP;
              tx_q     <= 1'b1;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        STOP: begin
          tx_q <= 1'b1;
          if (s_tick) begin
            if (tick_cnt == stop_last_c) begin
              tick_cnt <= '0;
              state    <= IDLE;
            end else begin
              tick_cnt <= tick_cnt + TICK_W'(1);
            end
          end
        end
        BREAK: begin
          tx_q <= 1'b0;
          // Release uses the stop length presented at the moment of release.
          if (!send_break) begin
            state     <= STOP;
            stop_q    <= cfg_stop;
            brk_seq_q <= 1'b1;
            tick_cnt  <= '0;
            tx_q      <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx_q  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: stimulus queues the hand-derived line
// waveform per frame; a monitor records tx on every s_tick while busy and
// checks the recorded trace when the frame ends.
module tb_uart_tx_cfg;

  localparam int OS = 16;

  logic       clk;
  logic       reset_in;
  logic       s_tick;
  logic       tx_valid;
  logic       tx_ready;
  logic [8:0] tx_data;
  logic [3:0] cfg_dbits;
  logic [1:0] cfg_parity;
  logic [1:0] cfg_stop;
  logic       send_break;
  logic       tx;
  logic       tx_done_tick;
  logic       busy;

  uart_tx_cfg #(.OS_TICKS(16), .MAX_DATA_W(9)) dut (
    .clk          (clk),
    .reset_in     (reset_in),
    .s_tick       (s_tick),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .cfg_dbits    (cfg_dbits),
    .cfg_parity   (cfg_parity),
    .cfg_stop     (cfg_stop),
    .send_break   (send_break),
    .tx           (tx),
    .tx_done_tick (tx_done_tick),
    .busy         (busy)
  );

  // kind 0: full frame, 1: break sequence, 2: frame aborted by reset
  typedef struct {
    int    kind;
    string bits;
    int    stop_ticks;
  } exp_t;

  exp_t sb[$];
  logic trace[$];
  bit   in_frame;
  int   checks;
  int   errors;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One-clock s_tick every 4 clocks.
  initial begin
    s_tick = 1'b0;
    forever begin
      repeat (3) @(posedge clk);
      #1 s_tick = 1'b1;
      @(posedge clk);
      #1 s_tick = 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic finalize(input int done);
    exp_t e;
    logic ex[$];
    int   idx;
    int   z;
    int   o;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame actual_ticks=%0d required=no_frame", trace.size());
    end else begin
      e = sb.pop_front();
      for (int i = 0; i < e.bits.len(); i++)
        for (int k = 0; k < OS; k++) ex.push_back(e.bits[i] == "1");
      for (int k = 0; k < e.stop_ticks; k++) ex.push_back(1'b1);
      if (e.kind == 1) begin
        z = 0;
        while (z < trace.size() && trace[z] == 1'b0) z++;
        o = 0;
        while (z + o < trace.size() && trace[z + o] == 1'b1) o++;
        chk("break_done_pulse", done, 0);
        chk("break_low_ticks_seen", int'(z > 0), 1);
        chk("break_stop_ticks", o, e.stop_ticks);
        chk("break_trace_shape", z + o, trace.size());
      end else begin
        idx = -1;
        for (int i = 0; i < trace.size() && i < ex.size(); i++)
          if (idx < 0 && trace[i] != ex[i]) idx = i;
        if (e.kind == 0) begin
          chk($sformatf("frame_%s_ticks", e.bits), trace.size(), ex.size());
          chk($sformatf("frame_%s_first_bad_tick", e.bits), idx, -1);
          chk($sformatf("frame_%s_done", e.bits), done, 1);
        end else begin
          chk("abort_prefix_first_bad_tick", idx, -1);
          chk("abort_short", int'(trace.size() < ex.size()), 1);
          chk("abort_done_pulse", done, 0);
        end
      end
    end
    trace.delete();
    in_frame = 1'b0;
  endtask

  // Monitor: record line value on each strobe while busy, check at frame end.
  initial begin
    in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (busy) begin
        in_frame = 1'b1;
        if (s_tick) trace.push_back(tx);
      end
      if (in_frame && tx_done_tick) finalize(1);
      else if (in_frame && !busy) finalize(0);
    end
  end

  task automatic issue(input logic [8:0] d, input logic [3:0] db, input logic [1:0] par,
                       input logic [1:0] st, input string bits, input int stop_ticks,
                       input int kind);
    exp_t e;
    int   n;
    e.kind = kind;
    e.bits = bits;
    e.stop_ticks = stop_ticks;
    sb.push_back(e);
    @(posedge clk);
    #1;
    tx_data    = d;
    cfg_dbits  = db;
    cfg_parity = par;
    cfg_stop   = st;
    tx_valid   = 1'b1;
    n = 0;
    @(negedge clk);
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout actual_ready=0 required=1");
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    chk("tx_low_after_accept", tx, 0);
    chk("busy_after_accept", busy, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", busy, 0);
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    checks     = 0;
    errors     = 0;
    reset_in   = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = '0;
    cfg_dbits  = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop   = 2'b00;
    send_break = 1'b0;

    repeat (3) @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_busy", busy, 0);
    chk("reset_ready", tx_ready, 0);
    chk("reset_done", tx_done_tick, 0);
    @(posedge clk);
    #1 reset_in = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_reset", tx_ready, 1);

    // 8N1 0x0A5
    issue(9'h0A5, 4'd8, 2'b00, 2'b00, "010100101", 16, 0);
    wait_idle();
    chk("ready_after_frame", tx_ready, 1);

    // 7E2 0x1FF: seven ones, parity 1, two stop bits
    issue(9'h1FF, 4'd7, 2'b01, 2'b10, "011111111", 32, 0);
    wait_idle();

    // 5O1.5 0x003: data 1,1,0,0,0, parity 1
    issue(9'h003, 4'd5, 2'b10, 2'b01, "0110001", 24, 0);
    wait_idle();

    // cfg changed mid-frame; the frame in flight keeps 8N1
    issue(9'h03C, 4'd8, 2'b00, 2'b00, "000111100", 16, 0);
    repeat (200) @(posedge clk);
    #1;
    cfg_dbits  = 4'd6;
    cfg_parity = 2'b01;
    cfg_stop   = 2'b10;
    wait_idle();
    issue(9'h03C, 4'd6, 2'b00, 2'b00, "0001111", 16, 0);
    wait_idle();

    // illegal dbits 15 -> 8, parity mode 11 -> none, stop 11 -> 2 bits
    issue(9'h155, 4'hF, 2'b11, 2'b11, "010101010", 32, 0);
    wait_idle();

    // 9E1: five ones -> parity 1
    issue(9'h155, 4'd9, 2'b01, 2'b00, "01010101011", 16, 0);
    wait_idle();

    // dbits 0 -> 8, odd parity over four ones -> 1
    issue(9'h0F0, 4'd0, 2'b10, 2'b00, "0000011111", 16, 0);
    wait_idle();

    // break wins over a simultaneous frame offer
    begin
      exp_t e;
      e.kind = 1;
      e.bits = "";
      e.stop_ticks = 16;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    send_break = 1'b1;
    tx_valid   = 1'b1;
    tx_data    = 9'h0AA;
    cfg_stop   = 2'b00;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("break_ready_low", tx_ready, 0);
      if (i >= 1) chk("break_tx_low", tx, 0);
    end
    @(posedge clk);
    #1;
    send_break = 1'b0;
    tx_valid   = 1'b0;
    wait_idle();
    chk("ready_after_break", tx_ready, 1);

    // reset during data bit 3 (a zero bit of 0x0A5)
    issue(9'h0A5, 4'd8, 2'b00, 2'b00, "010100101", 16, 2);
    repeat (276) @(posedge clk);
    #1;
    chk("tx_before_reset", tx, 0);
    reset_in = 1'b0;
    #1;
    chk("abort_tx_high", tx, 1);
    chk("abort_busy_low", busy, 0);
    chk("abort_ready_low", tx_ready, 0);
    chk("abort_done_low", tx_done_tick, 0);
    repeat (3) @(posedge clk);
    #1 reset_in = 1'b1;
    @(posedge clk);
    #1 chk("ready_after_abort_reset", tx_ready, 1);
    issue(9'h05A, 4'd8, 2'b00, 2'b00, "001011010", 16, 0);
    wait_idle();

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter OS_TICKS, default 16, meaning s_tick pulses per bit period; legal values are even and 4..32.
REQ-002 SHALL have parameter MAX_DATA_W, default 9, meaning width of tx_data; fixed at 9.
REQ-003 SHALL have port clk  in  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_in  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port s_tick  in  1  oversampling strobe; one clk wide, OS_TICKS per bit period.
REQ-006 SHALL have port tx_valid  in  1  a frame is offered on tx_data.
REQ-007 SHALL have port tx_ready  out  1  the block accepts a frame this cycle.
REQ-008 SHALL have port tx_data  in  9  frame payload, LSB first.
REQ-009 SHALL have port cfg_dbits  in  4  data bit count; legal 5..9, any other value is treated as 8.
REQ-010 SHALL have port cfg_parity  in  2  parity mode: 00 none, 01 even, 10 odd, 11 none.
REQ-011 SHALL have port cfg_stop  in  2  stop length: 00 is 1 bit, 01 is 1.5 bits, 10 and 11 are 2 bits.
REQ-012 SHALL have port send_break  in  1  request to hold the line low.
REQ-013 SHALL have port tx  out  1  serial line, registered, idle high.
REQ-014 SHALL have port tx_done_tick  out  1  one-cycle pulse at the end of a frame.
REQ-015 SHALL have port busy  out  1  high whenever the state is not IDLE.

Function
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP and BREAK.
REQ-017 SHALL drive tx_ready = 1 only when the state is IDLE and send_break = 0.
REQ-018 SHALL accept a frame when tx_valid and tx_ready are both 1, and on that edge SHALL latch tx_data, cfg_dbits, cfg_parity and cfg_stop.
REQ-019 SHALL ignore cfg changes made mid-frame; only the latched values govern the frame in flight.
REQ-020 SHALL drive tx = 0 from the first clk after acceptance, i.e. a latency of 1 cycle.
REQ-021 SHALL NOT count an s_tick that coincides with the acceptance cycle toward the start bit.
REQ-022 SHALL hold START, each DATA bit and PARITY for exactly OS_TICKS counted s_ticks each.
REQ-023 SHALL hold STOP for OS_TICKS, 3*OS_TICKS/2 or 2*OS_TICKS s_ticks for cfg_stop 1, 1.5 or 2 bits respectively.
REQ-024 SHALL shift DATA LSB first and send exactly the latched bit count; tx_data bits above that count are ignored.
REQ-025 SHALL compute parity only over the transmitted data bits: even gives XOR of those bits, odd gives its inverse.
REQ-026 SHALL skip the PARITY state when the parity mode is none.
REQ-027 SHALL drive tx = 1 in STOP.
REQ-028 SHALL pulse tx_done_tick for one cycle on the cycle the final STOP s_tick is counted, enter IDLE on the next edge, and raise tx_ready one cycle after that pulse.
REQ-029 SHALL NOT change state or counters in any cycle without s_tick, other than acceptance and break entry.
REQ-030 SHALL, when IDLE and send_break = 1, enter BREAK and drive tx = 0 for as long as send_break stays 1, regardless of s_tick.
REQ-031 SHALL, when send_break falls in BREAK, enter STOP with the current cfg_stop length and then return to IDLE, and SHALL NOT pulse tx_done_tick for this sequence.
REQ-032 SHALL give send_break priority over a simultaneous tx_valid; the offered frame is not accepted.
REQ-033 SHALL ignore send_break asserted mid-frame until the block returns to IDLE.
REQ-034 SHALL size the tick counter to hold 2*OS_TICKS-1 and the bit counter to hold 0..8, with no wrap within a frame.

Reset
REQ-035 SHALL, while reset_in = 0, force state IDLE, tx = 1, tx_done_tick = 0, busy = 0, tx_ready = 0 and all counters and shift registers to 0.
REQ-036 SHALL take effect immediately on reset_in assertion mid-frame, abort the frame and drive tx = 1 asynchronously; no tx_done_tick follows.
REQ-037 SHALL drive tx_ready = 1 on the first clk after reset_in deasserts, provided send_break = 0.

Verification
REQ-038 SHALL cover 8N1, OS_TICKS = 16, tx_data = 0x0A5 -> tx sequence 0,1,0,1,0,0,1,0,1,1 with each bit lasting 16 ticks, and tx_done_tick on the 160th counted tick.
REQ-039 SHALL cover cfg 7E2, tx_data = 0x1FF -> 7 ones, parity 1, 2 stop bits (32 ticks), 11 bit periods total, data bits 8 and 9 not sent.
REQ-040 SHALL cover cfg 5O1.5, tx_data = 0x003 -> data 1,1,0,0,0, parity 1, STOP lasting 24 ticks.
REQ-041 SHALL cover a cfg_dbits change to 6 during the DATA state of an 8-bit frame -> 8 bits are still sent; the next frame uses 6.
REQ-042 SHALL cover send_break and tx_valid both 1 in IDLE for 50 cycles -> tx = 0, tx_ready = 0; after release, 16 ticks of tx = 1, then IDLE, with no tx_done_tick.
REQ-043 SHALL cover reset_in pulsed low at DATA bit 3 -> tx = 1 immediately, busy = 0, and a clean 8N1 frame is sent after release.
